result_checker: RTL

Result-side consumer that drains the result FIFO filled by the DUT interface stage and compares each captured DUT output word against an expected word with a per-bit don't-care mask. The expected/mask pairs come from a separate expected-value FIFO loaded by the host. The block keeps pass/fail counts and records the first failing vector, so the host reads a compact verdict instead of raw results. It sustains one comparison per clock when both FIFOs have data.

---
 rtl/result_checker.sv | 119 +++++++++++
 1 files changed

// File: rtl/result_checker.sv
// Drains paired result/expected FIFOs, compares each result under a per-bit mask,
// and keeps pass/fail counts plus a record of the first failing vector.
module result_checker #(
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [RTF_WIDTH-1:0]   rfifo_data,
  output logic                   rfifo_rdreq,
  input  logic                   rfifo_rdempty,
  input  logic [2*RTF_WIDTH-1:0] efifo_data,
  output logic                   efifo_rdreq,
  input  logic                   efifo_rdempty,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   num_vectors,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   pass_count,
  output logic [CNT_WIDTH-1:0]   fail_count,
  output logic                   first_fail_valid,
  output logic [CNT_WIDTH-1:0]   first_fail_idx,
  output logic [RTF_WIDTH-1:0]   first_fail_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   num_reg;
  logic [CNT_WIDTH-1:0]   issued;
  logic [CNT_WIDTH-1:0]   compared;
  logic                   rd_d1;
  logic                   rd_en;
  logic                   start_ok;
  logic                   last_cmp;
  logic                   mismatch;
  logic [RTF_WIDTH-1:0]   exp_word;
  logic [RTF_WIDTH-1:0]   mask_word;

  assign exp_word  = efifo_data[RTF_WIDTH-1:0];
  assign mask_word = efifo_data[2*RTF_WIDTH-1:RTF_WIDTH];
  assign mismatch  = |((rfifo_data ^ exp_word) & mask_word);
  assign start_ok  = start & ~abort & (state != RUN);
  assign last_cmp  = rd_d1 & (compared == (num_reg - CNT_ONE));

  assign rfifo_rdreq = rd_en;
  assign efifo_rdreq = rd_en;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Both FIFOs are always popped together so result/expected pairs never slip.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_ok) state_next = (num_vectors == '0) ? DONE : RUN;
      end
      RUN: begin
        rd_en = ~rfifo_rdempty & ~efifo_rdempty & (issued != num_reg) & ~abort;
        if (abort)         state_next = IDLE;
        else if (last_cmp) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A compare still in flight when a run is aborted completes after the return to IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_d1            <= 1'b0;
      num_reg          <= '0;
      issued           <= '0;
      compared         <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_data  <= '0;
    end else begin
      rd_d1 <= rd_en;
      if (start_ok) begin
        num_reg          <= num_vectors;
        issued           <= '0;
        compared         <= '0;
        pass_count       <= '0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
        first_fail_data  <= '0;
      end else begin
        if (rd_en) issued <= issued + CNT_ONE;
        if (rd_d1) begin
          if (compared != CNT_MAX) compared <= compared + CNT_ONE;
          if (mismatch) begin
            if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_ONE;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= compared;
              first_fail_data  <= rfifo_data;
            end
          end else begin
            if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_ONE;
          end
        end
      end
    end
  end

endmodule
